// File: rtl/fx_fp_pkg.sv
// Shared fixed/float definitions for the int<->float sequential converters:
// FSM state encoding and float word field positions.
package fx_fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } fx_state_e;

  // Default float word geometry: {sign, expo[7:0], mant[22:0]}
  localparam int FP_NUBITS = 32;
  localparam int FP_NBMANT = 23;
  localparam int FP_NBEXPO = 8;

  function automatic int fp_sign_pos(input int nubits);
    return nubits - 1;
  endfunction

  function automatic int fp_expo_lsb(input int nbmant);
    return nbmant;
  endfunction

  function automatic int fp_expo_msb(input int nbmant, input int nbexpo);
    return nbmant + nbexpo - 1;
  endfunction

endpackage

// File: rtl/i2f_pack.sv
// Float word assembly: {sign, expo, mant}, with the zero value forced to the
// all-zero word regardless of sign/expo.
module i2f_pack
  import fx_fp_pkg::*;
#(
  parameter int NUBITS = FP_NUBITS,
  parameter int NBMANT = FP_NBMANT,
  parameter int NBEXPO = FP_NBEXPO
) (
  input  logic              sign,
  input  logic [NBEXPO-1:0] expo,
  input  logic [NBMANT-1:0] mant,
  input  logic              zero,
  output logic [NUBITS-1:0] word
);

  localparam int SIGN_POS = fp_sign_pos(NUBITS);
  localparam int EXPO_LSB = fp_expo_lsb(NBMANT);
  localparam int EXPO_MSB = fp_expo_msb(NBMANT, NBEXPO);

  always_comb begin
    word = '0;
    if (!zero) begin
      word[SIGN_POS]          = sign;
      word[EXPO_MSB:EXPO_LSB] = expo;
      word[NBMANT-1:0]        = mant;
    end
  end

endmodule

// File: rtl/i2f_seq.sv
// Sequential signed-int to float converter, one normalizing shift per cycle.
// Optional round-half-up on right-shift truncation: define I2F_ROUND_EN.
module i2f_seq
  import fx_fp_pkg::*;
#(
  parameter int NUBITS = 32,
  parameter int NBMANT = 23,
  parameter int NBEXPO = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUBITS-1:0] in,
  output logic              busy,
  output logic              done,
  output logic [NUBITS-1:0] out
);

  fx_state_e          state;
  logic               sign;
  logic [NUBITS-1:0]  mag;
  logic [NBEXPO-1:0]  expo;
  logic [NUBITS-1:0]  in_mag;
  logic [NBMANT-1:0]  mant_fin;
  logic [NUBITS-1:0]  pack_word;
  logic               mag_zero;
  logic               hi_nz;
  logic               norm_ok;

  // Two's-complement negate; -2^(NUBITS-1) maps to 2^(NUBITS-1) as unsigned.
  assign in_mag   = in[NUBITS-1] ? (~in + NUBITS'(1)) : in;
  assign mag_zero = (mag == '0);
  assign hi_nz    = |mag[NUBITS-1:NBMANT];
  assign norm_ok  = mag[NBMANT-1];

`ifdef I2F_ROUND_EN
  logic              guard;
  logic [NBMANT:0]   rnd_sum;
  assign rnd_sum  = {1'b0, mag[NBMANT-1:0]} + {{NBMANT{1'b0}}, guard};
  assign mant_fin = rnd_sum[NBMANT-1:0];
`else
  assign mant_fin = mag[NBMANT-1:0];
`endif

  i2f_pack #(
    .NUBITS (NUBITS),
    .NBMANT (NBMANT),
    .NBEXPO (NBEXPO)
  ) u_pack (
    .sign (sign),
    .expo (expo),
    .mant (mant_fin),
    .zero (mag_zero),
    .word (pack_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      sign  <= 1'b0;
      mag   <= '0;
      expo  <= '0;
`ifdef I2F_ROUND_EN
      guard <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign  <= in[NUBITS-1];
            mag   <= in_mag;
            expo  <= '0;
`ifdef I2F_ROUND_EN
            guard <= 1'b0;
`endif
            state <= NORM;
            busy  <= 1'b1;
          end
        end
        NORM: begin
          if (mag_zero) begin
            out   <= pack_word;
            done  <= 1'b1;
            state <= DONE;
          end else if (hi_nz) begin
            mag   <= mag >> 1;
            expo  <= expo + NBEXPO'(1);
`ifdef I2F_ROUND_EN
            guard <= mag[0];
`endif
          end else if (!norm_ok) begin
            mag  <= mag << 1;
            expo <= expo - NBEXPO'(1);
`ifdef I2F_ROUND_EN
          end else if (rnd_sum[NBMANT]) begin
            // Round carried out of the mantissa: absorb it as one right shift.
            mag   <= NUBITS'(rnd_sum[NBMANT:1]);
            expo  <= expo + NBEXPO'(1);
            guard <= 1'b0;
`endif
          end else begin
            out   <= pack_word;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2f_seq.sv
// Directed bench for i2f_seq: hand-computed float words and latencies,
// honouring I2F_ROUND_EN when defined.
module tb_i2f_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] in;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  i2f_seq #(.NUBITS(32), .NBMANT(23), .NBEXPO(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one conversion and follow it to done. glitch=1 pulses start with a
  // junk value while busy, which must be ignored.
  task automatic conv(input string tag, input logic [31:0] v, input logic [31:0] exp_out,
                      input int exp_lat, input bit glitch);
    int edges;
    bit seen;
    @(negedge clk);
    in    = v;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    #1 start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (glitch && edges == 4) begin
        start = 1'b1;
        in    = 32'h0000_0005;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_out"}, out, exp_out);
    chk({tag, "_lat"}, edges, exp_lat);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    in    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out", out, 32'd0);
    rst = 1'b1;

    conv("one",  32'h0000_0001, 32'h7540_0000, 24, 1'b0);
    chk("one_hold", out, 32'h7540_0000);
    repeat (5) @(posedge clk);
    #1 chk("one_stable", out, 32'h7540_0000);

    conv("neg6", 32'hFFFF_FFFA, 32'hF660_0000, 22, 1'b0);
    conv("neg1", 32'hFFFF_FFFF, 32'hF540_0000, 24, 1'b0);
`ifdef I2F_ROUND_EN
    conv("maxp", 32'h7FFF_FFFF, 32'h04C0_0000, 11, 1'b0);
    conv("fff",  32'h00FF_FFFF, 32'h0140_0000, 4, 1'b0);
`else
    conv("maxp", 32'h7FFF_FFFF, 32'h047F_FFFF, 10, 1'b0);
    conv("fff",  32'h00FF_FFFF, 32'h00FF_FFFF, 3, 1'b0);
`endif
    conv("minn", 32'h8000_0000, 32'h84C0_0000, 11, 1'b0);
    conv("zero", 32'h0000_0000, 32'h0000_0000, 2, 1'b0);
    conv("bit22", 32'h0040_0000, 32'h0040_0000, 2, 1'b0);
    conv("bit23", 32'h0080_0000, 32'h00C0_0000, 3, 1'b0);
    conv("glitch", 32'h0000_0001, 32'h7540_0000, 24, 1'b1);

    // Reset in the middle of NORM, with start held high during reset edges.
    @(negedge clk);
    in    = 32'h0000_0001;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst   = 1'b0;
    start = 1'b1;
    in    = 32'h0000_0007;
    @(posedge clk);
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_out", out, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_start_ignored", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    conv("after_rst", 32'hFFFF_FFFA, 32'hF660_0000, 22, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
